hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard unit for the 5-stage MIPS core.
- Combines two functions:
  - Data forwarding: select signals for the Decode-stage branch comparator and the Execute-stage ALU operands.
  - Hazard detection: stall/flush generation for load-use, branch-operand and multiplier-busy (mfhi/mflo) hazards.
- Sits beside the datapath. Consumes stage register numbers and control bits, drives pipeline-register enables/clears and forwarding muxes.

Parameters:
- REG_W, 5, register-number width
- REG_ZERO, 0, hardwired zero register; never forwarded

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- BranchD  in  1  branch instruction in Decode
- MemtoRegE  in  1  load in Execute
- RegWriteE  in  1  Execute instruction writes register file
- MemtoRegM  in  1  load in Memory
- RegWriteM  in  1  Memory instruction writes register file
- RegWriteW  in  1  Writeback instruction writes register file
- RsD  in  5  Decode source register s
- RtD  in  5  Decode source register t
- RsE  in  5  Execute source register s
- RtE  in  5  Execute source register t
- WriteRegE  in  5  Execute destination register
- WriteRegM  in  5  Memory destination register
- WriteRegW  in  5  Writeback destination register
- multReady  in  1  multiplier result valid (HI/LO updated)
- mfReg  in  2  Decode move-from: 00 none, 01 mfhi, 10 mflo, 11 treated as move
- multStart  in  1  multiply issued this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushE  out  1  clear ID/EX register
- ForwardAD  out  1  forward ALUOutM to branch comparator A
- ForwardBD  out  1  forward ALUOutM to branch comparator B
- ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUOutM
- ForwardBE  out  2  SrcB select, same encoding

Behaviour:
- All outputs are combinational from the inputs plus one internal flag, multBusy. There is no output latency.
- Clocked state is multBusy only:
  - On a posedge of clk with reset=1: multBusy <= 0.
  - Otherwise, if multReady=1: multBusy <= 0. multReady has priority over multStart.
  - Otherwise, if multStart=1: multBusy <= 1.
  - Otherwise: multBusy holds.
- ForwardAE:
  - 10 if RsE!=0 && RsE==WriteRegM && RegWriteM.
  - Else 01 if RsE!=0 && RsE==WriteRegW && RegWriteW.
  - Else 00.
  - The Memory stage wins when both stages match.
- ForwardBE: identical rule using RtE.
- ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM.
- ForwardBD = RtD!=0 && RtD==WriteRegM && RegWriteM.
- lwstall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchstall = BranchD && (A || B), where:
  - A = RegWriteE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD)
  - B = MemtoRegM && WriteRegM!=0 && (WriteRegM==RsD || WriteRegM==RtD)
- multstall = (mfReg!=00) && (multBusy || multStart) && !multReady.
- StallF = StallD = FlushE = lwstall || branchstall || multstall.
- Simultaneous hazards OR together; outputs are never pulsed or latched.
- While reset=1, outputs still follow the combinational rules. Only multBusy is cleared.
- Reset mid-multiply clears multBusy. multstall then drops on the next cycle unless multStart is asserted again.
- Register 0 never causes forwarding or a stall.

Decomposition:
- Shared package (hazard_pkg):
  - localparams for the forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - MF_NONE/MF_HI/MF_LO for the mfReg encoding
  - REG_W
- One sub-module, data_forwarding: purely combinational and produces ForwardAD/BD/AE/BE.
- hazard_unit instantiates data_forwarding and contains the stall logic and the multBusy flag.

Test Plan:
- Forward A from Memory: RsE=5, WriteRegM=5, RegWriteM=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=00.
- Forward B from Writeback: RtE=6, WriteRegW=6, RegWriteW=1 with no Memory match -> ForwardBE=01. Then RegWriteW=0 -> 00. Also set RtE=6, WriteRegM=6, RegWriteM=1 -> 10 (priority). Also RtE=0, WriteRegW=0, RegWriteW=1 -> 00.
- Decode forward: RsD=7, WriteRegM=7, RegWriteM=1 -> ForwardAD=1, ForwardBD=0 (RtD≠7).
- Branch stall: BranchD=1, RegWriteE=1, WriteRegE=15, RsD=15 -> StallF=StallD=FlushE=1. Then RegWriteE=0 with MemtoRegM=0 -> all 0.
- Load-use stall: MemtoRegE=1, RtE=15, RsD=15 -> stall outputs 1. Then MemtoRegE=0 -> 0.
- Multiplier:
  - After reset, multStart=1 for one cycle; mfReg=01 held with multReady=0 -> stall outputs stay 1 across cycles.
  - multReady=1 -> stall outputs 0 immediately and multBusy clears at the next edge.
  - reset=1 mid-busy -> stall outputs drop on the cycle after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding mux selects,
// move-from-HI/LO codes and the register-number width.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

endpackage

// File: rtl/data_forwarding.sv
// Forwarding select generation for the Decode branch comparator and the
// Execute ALU operands. Purely combinational.
module data_forwarding #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter logic [REG_W-1:0] REG_ZERO = '0
) (
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
);
    import hazard_pkg::*;

    function automatic logic [1:0] exec_sel(input logic [REG_W-1:0] src,
                                            input logic [REG_W-1:0] wr_m,
                                            input logic             we_m,
                                            input logic [REG_W-1:0] wr_w,
                                            input logic             we_w);
        logic [1:0] sel;
        sel = FWD_RF;
        // The Memory stage holds the younger value, so it is checked first.
        if (src != REG_ZERO && src == wr_m && we_m) begin
            sel = FWD_MEM;
        end else if (src != REG_ZERO && src == wr_w && we_w) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = exec_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
        ForwardBE = exec_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
        ForwardAD = (RsD != REG_ZERO) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = (RtD != REG_ZERO) && (RtD == WriteRegM) && RegWriteM;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects plus stall/flush generation for
// load-use, branch-operand and multiplier-busy hazards.
module hazard_unit #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter logic [REG_W-1:0] REG_ZERO = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BranchD,
    input  logic             MemtoRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegM,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             multReady,
    input  logic [1:0]       mfReg,
    input  logic             multStart,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
);
    import hazard_pkg::*;

    logic mult_busy_q;
    logic mult_busy_d;
    logic lwstall;
    logic branchstall;
    logic multstall;
    logic stall;

    data_forwarding #(
        .REG_W    (REG_W),
        .REG_ZERO (REG_ZERO)
    ) u_data_forwarding (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // A completing result outranks a new issue in the same cycle.
    always_comb begin
        mult_busy_d = mult_busy_q;
        if (multReady) begin
            mult_busy_d = 1'b0;
        end else if (multStart) begin
            mult_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_busy_q <= 1'b0;
        end else begin
            mult_busy_q <= mult_busy_d;
        end
    end

    always_comb begin
        lwstall = MemtoRegE && (RtE != REG_ZERO) && ((RsD == RtE) || (RtD == RtE));

        branchstall = BranchD &&
            ((RegWriteE && (WriteRegE != REG_ZERO) &&
              ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
             (MemtoRegM && (WriteRegM != REG_ZERO) &&
              ((WriteRegM == RsD) || (WriteRegM == RtD))));

        multstall = (mfReg != MF_NONE) && (mult_busy_q || multStart) && !multReady;

        stall  = lwstall || branchstall || multstall;
        StallF = stall;
        StallD = stall;
        FlushE = stall;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       multReady, multStart;
    logic [1:0] mfReg;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;
    bit m_busy   = 1'b0;

    hazard_unit dut (
        .clk       (clk),
        .reset     (reset),
        .BranchD   (BranchD),
        .MemtoRegE (MemtoRegE),
        .RegWriteE (RegWriteE),
        .MemtoRegM (MemtoRegM),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegE (WriteRegE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .multReady (multReady),
        .mfReg     (mfReg),
        .multStart (multStart),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    always #5 clk = ~clk;

    // Reference: the multiplier is "outstanding" from an issue until a result or reset.
    always @(posedge clk) begin
        if (reset || multReady) m_busy <= 1'b0;
        else if (multStart)     m_busy <= 1'b1;
    end

    function automatic int exp_fwd_e(input logic [4:0] src);
        if (src == 0) return 0;
        if (RegWriteM && WriteRegM == src) return 2;
        if (RegWriteW && WriteRegW == src) return 1;
        return 0;
    endfunction

    function automatic int exp_fwd_d(input logic [4:0] src);
        return (src != 0 && RegWriteM && WriteRegM == src) ? 1 : 0;
    endfunction

    function automatic int exp_stall();
        bit reads_e, reads_m, lw, br, mf;
        lw = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
        reads_e = WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
        reads_m = WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD);
        br = BranchD && ((RegWriteE && reads_e) || (MemtoRegM && reads_m));
        mf = mfReg != 2'b00 && (m_busy || multStart) && !multReady;
        return (lw || br || mf) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("m_ForwardAE", int'(ForwardAE), exp_fwd_e(RsE));
            check("m_ForwardBE", int'(ForwardBE), exp_fwd_e(RtE));
            check("m_ForwardAD", int'(ForwardAD), exp_fwd_d(RsD));
            check("m_ForwardBD", int'(ForwardBD), exp_fwd_d(RtD));
            check("m_StallF",    int'(StallF),    exp_stall());
            check("m_StallD",    int'(StallD),    exp_stall());
            check("m_FlushE",    int'(FlushE),    exp_stall());
        end
    end

    task automatic idle();
        reset = 0; BranchD = 0; MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0;
        RegWriteM = 0; RegWriteW = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0; multReady = 0; multStart = 0;
        mfReg = 2'b00;
    endtask

    // Advance to just after the next posedge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic chk_stall(input string name, input int expected);
        check({name, "_StallF"}, int'(StallF), expected);
        check({name, "_StallD"}, int'(StallD), expected);
        check({name, "_FlushE"}, int'(FlushE), expected);
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        model_on = 1'b1;
        at_sample();
        chk_stall("reset_idle", 0);
        check("reset_ForwardAE", int'(ForwardAE), 0);

        // Forwarding from Memory / Writeback
        step(); reset = 0; RsE = 5; WriteRegM = 5; RegWriteM = 1;
        at_sample(); check("fwdA_mem", int'(ForwardAE), 2);
        step(); RegWriteM = 0;
        at_sample(); check("fwdA_mem_off", int'(ForwardAE), 0);
        step(); idle(); RtE = 6; WriteRegW = 6; RegWriteW = 1;
        at_sample(); check("fwdB_wb", int'(ForwardBE), 1);
        step(); RegWriteW = 0;
        at_sample(); check("fwdB_wb_off", int'(ForwardBE), 0);
        step(); RegWriteW = 1; WriteRegM = 6; RegWriteM = 1;
        at_sample(); check("fwdB_prio", int'(ForwardBE), 2);
        step(); idle(); RtE = 0; WriteRegW = 0; RegWriteW = 1;
        at_sample(); check("fwdB_zero", int'(ForwardBE), 0);

        // Decode forwarding
        step(); idle(); RsD = 7; RtD = 3; WriteRegM = 7; RegWriteM = 1;
        at_sample(); check("fwdAD", int'(ForwardAD), 1); check("fwdBD", int'(ForwardBD), 0);

        // Branch and load-use stalls
        step(); idle(); BranchD = 1; RegWriteE = 1; WriteRegE = 15; RsD = 15;
        at_sample(); chk_stall("br", 1);
        step(); RegWriteE = 0;
        at_sample(); chk_stall("br_off", 0);
        step(); idle(); MemtoRegE = 1; RtE = 15; RsD = 15;
        at_sample(); chk_stall("lw", 1);
        step(); MemtoRegE = 0;
        at_sample(); chk_stall("lw_off", 0);
        step(); MemtoRegE = 1; RtE = 0; RsD = 0;
        at_sample(); chk_stall("lw_r0", 0);

        // Multiplier busy
        step(); idle(); mfReg = 2'b01; multStart = 1;
        at_sample(); chk_stall("mul_start", 1);
        step(); multStart = 0;
        at_sample(); chk_stall("mul_busy1", 1);
        step();
        at_sample(); chk_stall("mul_busy2", 1);
        step(); multReady = 1;
        at_sample(); chk_stall("mul_ready", 0);
        step(); multReady = 0;
        at_sample(); chk_stall("mul_cleared", 0);
        step(); multStart = 1;
        at_sample(); chk_stall("mul_start2", 1);
        step(); multStart = 0; reset = 1;
        at_sample(); chk_stall("mul_in_reset", 1);
        step(); reset = 0;
        at_sample(); chk_stall("mul_after_reset", 0);

        // Randomized traffic; small register range makes matches common.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset     = ($urandom_range(0, 31) == 0);
            BranchD   = $urandom_range(0, 1);
            MemtoRegE = $urandom_range(0, 1);
            RegWriteE = $urandom_range(0, 1);
            MemtoRegM = $urandom_range(0, 1);
            RegWriteM = $urandom_range(0, 1);
            RegWriteW = $urandom_range(0, 1);
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            RsE       = 5'($urandom_range(0, 3));
            RtE       = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = (i % 50 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            multReady = ($urandom_range(0, 5) == 0);
            multStart = ($urandom_range(0, 4) == 0);
            mfReg     = 2'($urandom_range(0, 3));
        end
        at_sample();
        model_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
